// File: rtl/div_sequencer.sv
// div_sequencer
//   Streams a buffer of IEEE-754 single-precision numerators through an
//   external divider that speaks the stb/ack handshake. Every numerator is
//   divided by one common divisor, and each quotient is written back into a
//   result buffer at the same index as its numerator.
//
//   Build option: define DIV_SEQ_TIMEOUT_EN to enable a 1024-cycle watchdog
//   in WAIT_Z. When it expires, err is set and the job ends early. Without
//   the macro, WAIT_Z waits indefinitely and err is tied to 0.
//
//   Ports
//     clk, rst                     clock; synchronous active-high reset
//                                  (the divider shares rst)
//     wr_en, wr_addr, wr_data      numerator buffer write port
//                                  (ignored while busy)
//     rd_addr, rd_data             result buffer read port, one-cycle
//                                  registered read
//     start, denom, len            job request: divisor and element count
//     busy, done, err              job status; done is a one-cycle pulse
//     output_a/_stb/_ack           dividend to the divider
//     output_b/_stb/_ack           divisor to the divider
//     input_z/_stb/_ack            quotient from the divider
//
//   state  | meaning
//   IDLE   | waiting for start
//   SEND_A | presenting numerator[index] on output_a
//   SEND_B | presenting the latched divisor on output_b
//   WAIT_Z | accepting the quotient from the divider
//   NEXT   | advance index, decide whether the job is complete
//   FINISH | one-cycle done pulse, then back to IDLE
module div_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          start,
    input  logic [31:0]   denom,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   output_a,
    output logic          output_a_stb,
    input  logic          output_a_ack,
    output logic [31:0]   output_b,
    output logic          output_b_stb,
    input  logic          output_b_ack,
    input  logic [31:0]   input_z,
    input  logic          input_z_stb,
    output logic          input_z_ack
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        NEXT,
        FINISH
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [AW:0]   index;
    logic [AW:0]   index_inc;
    logic [AW:0]   len_q;
    logic [AW:0]   len_clamped;
    logic [31:0]   denom_q;
    logic          z_xfer;
    logic          tmo_hit;

    logic [31:0]   num_mem [DEPTH];
    logic [31:0]   res_mem [DEPTH];

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
    assign index_inc   = index + (AW+1)'(1);
    assign busy        = (state != IDLE);
    assign z_xfer      = (state == WAIT_Z) && input_z_stb;

    // The numerator buffer cannot change while busy, so output_a is stable
    // for the whole of SEND_A even though it is read combinationally.
    assign output_a = num_mem[index[AW-1:0]];
    assign output_b = denom_q;

    always_comb begin
        state_next   = state;
        output_a_stb = 1'b0;
        output_b_stb = 1'b0;
        input_z_ack  = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? FINISH : SEND_A;
                end
            end
            SEND_A: begin
                output_a_stb = 1'b1;
                if (output_a_ack) begin
                    state_next = SEND_B;
                end
            end
            SEND_B: begin
                output_b_stb = 1'b1;
                if (output_b_ack) begin
                    state_next = WAIT_Z;
                end
            end
            WAIT_Z: begin
                input_z_ack = 1'b1;
                // A quotient arriving on the last watchdog cycle still wins.
                if (input_z_stb) begin
                    state_next = NEXT;
                end else if (tmo_hit) begin
                    state_next = FINISH;
                end
            end
            NEXT: begin
                state_next = (index_inc == len_q) ? FINISH : SEND_A;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            index   <= '0;
            len_q   <= '0;
            denom_q <= '0;
            rd_data <= '0;
        end else begin
            state   <= state_next;
            rd_data <= res_mem[rd_addr];
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        denom_q <= denom;
                        len_q   <= len_clamped;
                        index   <= '0;
                    end
                end
                NEXT: begin
                    index <= index_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer storage is not reset; results survive both rst and start.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            num_mem[wr_addr] <= wr_data;
        end
        if (!rst && z_xfer) begin
            res_mem[index[AW-1:0]] <= input_z;
        end
    end

`ifdef DIV_SEQ_TIMEOUT_EN
    logic [9:0] tmo_cnt;
    logic       err_q;

    // Down-counter reloads outside WAIT_Z and reaches zero on the 1024th
    // WAIT_Z cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '1;
            err_q   <= 1'b0;
        end else begin
            if (state != WAIT_Z) begin
                tmo_cnt <= '1;
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 10'd1;
            end
            if ((state == IDLE) && start && (len != '0)) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign tmo_hit = (state == WAIT_Z) && !input_z_stb && (tmo_cnt == '0);
    assign err     = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          start;
    logic [31:0]   denom;
    logic [AW:0]   len;
    logic          busy, done, err;
    logic [31:0]   output_a, output_b, input_z;
    logic          output_a_stb, output_a_ack;
    logic          output_b_stb, output_b_ack;
    logic          input_z_stb, input_z_ack;

    always #5 clk = ~clk;

    div_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .start(start), .denom(denom), .len(len),
        .busy(busy), .done(done), .err(err),
        .output_a(output_a), .output_a_stb(output_a_stb), .output_a_ack(output_a_ack),
        .output_b(output_b), .output_b_stb(output_b_stb), .output_b_ack(output_b_ack),
        .input_z(input_z), .input_z_stb(input_z_stb), .input_z_ack(input_z_ack)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- divider model ----------------
    logic [1:0]  m_st;
    logic [31:0] m_a, m_b;
    int          a_wait;
    int          a_delay = 0;
    bit          z_never = 1'b0;
    bit          b_block = 1'b0;

    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C00000, 32'h40000000}: quot = 32'h40400000;
            {32'h3F800000, 32'h40800000}: quot = 32'h3E800000;
            {32'h40000000, 32'h40800000}: quot = 32'h3F000000;
            {32'h40800000, 32'h40800000}: quot = 32'h3F800000;
            {32'h3F800000, 32'h00000000}: quot = 32'h7F800000;
            {32'h80000000, 32'h40000000}: quot = 32'h80000000;
            default:                      quot = 32'hFFFFFFFF;
        endcase
    endfunction

    assign output_a_ack = (m_st == 2'd0) && (a_wait == 0);
    assign output_b_ack = (m_st == 2'd1) && !b_block;
    assign input_z_stb  = (m_st == 2'd3) && !z_never;

    always @(posedge clk) begin
        if (rst) begin
            m_st    <= 2'd0;
            a_wait  <= a_delay;
            input_z <= 32'h0;
        end else begin
            case (m_st)
                2'd0: begin
                    if (!output_a_stb) a_wait <= a_delay;
                    else if (a_wait == 0) begin
                        m_a  <= output_a;
                        m_st <= 2'd1;
                    end else a_wait <= a_wait - 1;
                end
                2'd1: if (output_b_stb && !b_block) begin
                    m_b  <= output_b;
                    m_st <= 2'd2;
                end
                2'd2: begin
                    input_z <= quot(m_a, m_b);
                    m_st    <= 2'd3;
                end
                default: if (input_z_ack && !z_never) begin
                    m_st   <= 2'd0;
                    a_wait <= a_delay;
                end
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_rd[$];
    bit          rd_req = 1'b0;
    bit          rd_seen;
    int          a_hold = 0, b_hold = 0, a_last_hold = 0;
    bit          a_xfer = 1'b0, b_xfer = 1'b0;
    logic [31:0] a_prev, b_prev;
    int          a_stb_cycles = 0, b_stb_cycles = 0, done_cnt = 0;

    always @(posedge clk) rd_seen <= rd_req;

    always @(negedge clk) begin
        if (rst) begin
            a_hold = 0; b_hold = 0; a_xfer = 1'b0; b_xfer = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (rd_seen) begin
                if (exp_rd.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL rd_unexpected: got %h expected none", rd_data);
                end else check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (a_xfer) check("a_stb_drop", {31'h0, output_a_stb}, 32'h0);
            if (output_a_stb) begin
                a_stb_cycles++;
                if (a_hold > 0) check("a_stable", output_a, a_prev);
                a_prev = output_a;
                a_hold++;
                a_xfer = output_a_ack;
                if (output_a_ack) begin
                    if (exp_a.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL a_unexpected: got %h expected none", output_a);
                    end else check("a_word", output_a, exp_a.pop_front());
                    a_last_hold = a_hold;
                    a_hold = 0;
                end
            end else begin
                a_hold = 0; a_xfer = 1'b0;
            end
            if (b_xfer) check("b_stb_drop", {31'h0, output_b_stb}, 32'h0);
            if (output_b_stb) begin
                b_stb_cycles++;
                if (b_hold > 0) check("b_stable", output_b, b_prev);
                b_prev = output_b;
                b_hold++;
                b_xfer = output_b_ack;
                if (output_b_ack) begin
                    if (exp_b.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL b_unexpected: got %h expected none", output_b);
                    end else check("b_word", output_b, exp_b.pop_front());
                    b_hold = 0;
                end
            end else begin
                b_hold = 0; b_xfer = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        rd_addr = a; rd_req = 1'b1; exp_rd.push_back(exp);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] d, input logic [AW:0] n, input int exp_cyc,
                           input string tag, input bit bw, input logic [AW-1:0] bw_addr,
                           input logic [31:0] bw_data);
        int cyc;
        int d0;
        bit seen;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; denom = d; len = n;
        @(posedge clk); #1;
        start = 1'b0;
        if (bw) begin
            wr_en = 1'b1; wr_addr = bw_addr; wr_data = bw_data;
        end
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) wr_en = 1'b0;
            if (done) begin
                seen = 1'b1;
                check({tag, "_busy_with_done"}, {31'h0, busy}, 32'h1);
            end
        end
        wr_en = 1'b0;
        check({tag, "_cycles"}, cyc, exp_cyc);
        @(negedge clk);
        check({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
        check({tag, "_done_after"}, {31'h0, done}, 32'h0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        int sa, sb, d0;
        bit seen;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        start = 1'b0; denom = '0; len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_a_stb", {31'h0, output_a_stb}, 32'h0);
        check("rst_b_stb", {31'h0, output_b_stb}, 32'h0);
        check("rst_z_ack", {31'h0, input_z_ack}, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single element, 6.0 / 2.0
        wr(0, 32'h40C00000);
        exp_a.push_back(32'h40C00000); exp_b.push_back(32'h40000000);
        run_job(32'h40000000, 1, 6, "single", 1'b0, '0, '0);
        check("single_a_hold", a_last_hold, 1);
        rd_check(0, 32'h40400000);

        // three elements / 4.0, with a write to entry 2 attempted mid-job
        wr(0, 32'h3F800000); wr(1, 32'h40000000); wr(2, 32'h40800000);
        foreach (exp_a[i]) ;
        exp_a.push_back(32'h3F800000); exp_a.push_back(32'h40000000); exp_a.push_back(32'h40800000);
        repeat (3) exp_b.push_back(32'h40800000);
        run_job(32'h40800000, 3, 16, "triple", 1'b1, 2, 32'h12345678);
        rd_check(0, 32'h3E800000);
        rd_check(1, 32'h3F000000);
        rd_check(2, 32'h3F800000);

        // divide by zero and negative zero; entry 1 must survive
        exp_a.push_back(32'h3F800000); exp_b.push_back(32'h00000000);
        run_job(32'h00000000, 1, 6, "divzero", 1'b0, '0, '0);
        rd_check(0, 32'h7F800000);
        wr(0, 32'h80000000);
        exp_a.push_back(32'h80000000); exp_b.push_back(32'h40000000);
        run_job(32'h40000000, 1, 6, "negzero", 1'b0, '0, '0);
        rd_check(0, 32'h80000000);
        rd_check(1, 32'h3F000000);

        // dividend ack held off for 5 cycles
        a_delay = 5;
        wr(0, 32'h40C00000);
        exp_a.push_back(32'h40C00000); exp_b.push_back(32'h40000000);
        run_job(32'h40000000, 1, 11, "a_delay", 1'b0, '0, '0);
        check("a_delay_hold", a_last_hold, 6);
        a_delay = 0;
        rd_check(0, 32'h40400000);

        // zero-length job
        sa = a_stb_cycles; sb = b_stb_cycles;
        run_job(32'h40000000, 0, 1, "len0", 1'b0, '0, '0);
        check("len0_no_a_stb", a_stb_cycles, sa);
        check("len0_no_b_stb", b_stb_cycles, sb);

        // len beyond DEPTH clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            wr(i[AW-1:0], 32'h3F800000);
            exp_a.push_back(32'h3F800000); exp_b.push_back(32'h40800000);
        end
        run_job(32'h40800000, 20, 81, "clamp", 1'b0, '0, '0);
        rd_check(15, 32'h3E800000);
        rd_check(2, 32'h3E800000);

        // divider never answers
        z_never = 1'b1;
        exp_a.push_back(32'h3F800000); exp_b.push_back(32'h40800000);
`ifdef DIV_SEQ_TIMEOUT_EN
        run_job(32'h40800000, 1, 1027, "timeout", 1'b0, '0, '0);
        check("timeout_err", {31'h0, err}, 32'h1);
`else
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; denom = 32'h40800000; len = 1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1100) @(negedge clk);
        check("hang_busy", {31'h0, busy}, 32'h1);
        check("hang_err", {31'h0, err}, 32'h0);
        check("hang_no_done", done_cnt - d0, 0);
`endif
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; z_never = 1'b0;
        @(negedge clk);
        check("recover_err", {31'h0, err}, 32'h0);
        check("recover_busy", {31'h0, busy}, 32'h0);

        // reset while the divisor is being offered
        rd_check(0, 32'h3E800000);
        b_block = 1'b1;
        exp_a.push_back(32'h3F800000);
        @(posedge clk); #1;
        start = 1'b1; denom = 32'h40800000; len = 1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (output_b_stb) seen = 1'b1;
        end
        check("b_stb_reached", {31'h0, seen}, 32'h1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_err", {31'h0, err}, 32'h0);
        check("mid_rst_a_stb", {31'h0, output_a_stb}, 32'h0);
        check("mid_rst_b_stb", {31'h0, output_b_stb}, 32'h0);
        check("mid_rst_z_ack", {31'h0, input_z_ack}, 32'h0);
        check("mid_rst_rd_data", rd_data, 32'h0);
        @(posedge clk); #1; rst = 1'b0; b_block = 1'b0;

        // normal operation after the abort
        wr(0, 32'h40C00000);
        exp_a.push_back(32'h40C00000); exp_b.push_back(32'h40000000);
        run_job(32'h40000000, 1, 6, "post_rst", 1'b0, '0, '0);
        rd_check(0, 32'h40400000);

        repeat (3) @(negedge clk);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        check("exp_rd_drained", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the number of entries in the numerator and result buffers (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, the buffer address width; AW = log2(DEPTH).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en / wr_addr / wr_data  input  1 / AW / 32  numerator buffer write port.
REQ-006 rd_addr  input  AW  result buffer read address; rd_data  output  32  registered read data, one cycle after rd_addr.
REQ-007 start  input  1  one-cycle job request; denom  input  32  IEEE-754 single divisor; len  input  AW+1  number of elements (0..DEPTH).
REQ-008 busy  output  1  job in progress; done  output  1  one-cycle completion pulse; err  output  1  sticky timeout flag (see Configuration).
REQ-009 output_a  output  32  dividend word; output_a_stb  output  1  dividend valid; output_a_ack  input  1  dividend accepted.
REQ-010 output_b  output  32  divisor word; output_b_stb  output  1  divisor valid; output_b_ack  input  1  divisor accepted.
REQ-011 input_z  input  32  quotient word; input_z_stb  input  1  quotient valid; input_z_ack  output  1  quotient accepted.

Function
REQ-012 SHALL be the initiator of the stb/ack protocol: a word transfers on a rising edge where its stb and ack are both 1.
REQ-013 SHALL hold each stb high and its data stable until the transfer edge, and SHALL drop that stb on the cycle after the transfer edge; stb never depends combinationally on ack.
REQ-014 FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, NEXT, FINISH.
REQ-015 IDLE: start=1 with len>0 -> latch denom and len, clear index and err, enter SEND_A; start=1 with len=0 -> enter FINISH; start ignored in every other state.
REQ-016 SEND_A: output_a = numerator[index], output_a_stb=1; on transfer -> SEND_B.
REQ-017 SEND_B: output_b = latched denom, output_b_stb=1; on transfer -> WAIT_Z.
REQ-018 WAIT_Z: input_z_ack=1; on transfer write input_z to result[index] -> NEXT.
REQ-019 NEXT: index+1; if the new index equals len -> FINISH, otherwise -> SEND_A.
REQ-020 FINISH: done=1 for exactly one cycle -> IDLE; busy=1 in every state except IDLE.
REQ-021 Sequencer overhead SHALL be 1 cycle per acknowledged word plus 1 NEXT cycle; total job time = divider latency plus 4 cycles per element, plus 1 cycle for FINISH.
REQ-022 wr_en while busy=1 SHALL be ignored (numerator buffer frozen during a job); reads are legal at any time and return the current result contents.
REQ-023 len > DEPTH SHALL be clamped to DEPTH.
REQ-024 Result buffer contents SHALL be undefined until written; results SHALL never be cleared by start.

Reset
REQ-025 rst SHALL force IDLE with busy=0, done=0, err=0, all stb outputs 0, input_z_ack=0, index=0, and rd_data=0, aborting any job mid-transfer; buffer contents are not cleared.
REQ-026 rst SHALL be applied to the attached divider on the same cycle so that both ends restart in their idle states.

Configuration
REQ-027 Macro DIV_SEQ_TIMEOUT_EN defined: a 10-bit counter runs in WAIT_Z; 1024 cycles without a z transfer -> set err, drop input_z_ack, enter FINISH (done pulses), remaining elements unprocessed.
REQ-028 Macro DIV_SEQ_TIMEOUT_EN undefined: no counter, WAIT_Z waits indefinitely, err tied to 0.

Verification
REQ-029 Write numerator[0]=0x40C00000, denom=0x40000000, len=1, start -> result[0]=0x40400000, done pulses once, busy falls with it.
REQ-030 Load numerators 0x3F800000, 0x40000000, 0x40800000, denom=0x40800000, len=3 -> results 0x3E800000, 0x3F000000, 0x3F800000 in order.
REQ-031 numerator 0x3F800000, denom=0x00000000 -> result 0x7F800000; 0x80000000 / 0x40000000 -> 0x80000000.
REQ-032 Divider model delays output_a_ack by 5 cycles -> output_a_stb and output_a stay stable for all 5 cycles, then exactly one transfer; len=0 start -> done on the next cycle, no stb asserted.
REQ-033 DIV_SEQ_TIMEOUT_EN defined, divider model never raises input_z_stb -> err=1 and done after 1024 WAIT_Z cycles; rst mid-SEND_B -> all outputs at reset values next cycle.
